// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types for the M-extension sequencer.
// MULDIV_SEQ_DIV_EN selects the full divider state set.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_func_t;

`ifdef MULDIV_SEQ_DIV_EN
    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_FIX,
        S_DONE
    } md_state_t;
`else
    typedef enum logic {
        S_IDLE,
        S_DONE
    } md_state_t;
`endif

    localparam int MD_MUL_LATENCY = 1;

endpackage

// File: rtl/muldiv.sv
// muldiv: combinational multiplier for MUL/MULH/MULHSU/MULHU.
// func is funct3[1:0]; y is the selected product half.
module muldiv #(
    parameter int W = 32
) (
    input  logic [1:0]   func,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    logic           a_sgn;
    logic           b_sgn;
    logic [2*W-1:0] a_x;
    logic [2*W-1:0] b_x;
    logic [2*W-1:0] prod;

    // Extend each operand by its signedness, then a 2W-bit product is exact
    always_comb begin
        a_sgn = (func != 2'b11) & a[W-1];
        b_sgn = ~func[1] & b[W-1];
        a_x   = {{W{a_sgn}}, a};
        b_x   = {{W{b_sgn}}, b};
        prod  = a_x * b_x;
        y     = (func == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
    end

endmodule

// File: rtl/muldiv_seq_div_iter.sv
// div_iter: restoring divider on unsigned magnitudes.
// One quotient bit per step; last flags the final step.
module div_iter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] quot_o,
    output logic [W-1:0] rem_o,
    output logic         last_o
);

    localparam int CW = $clog2(W);

    logic [W-1:0]  rem_q;
    logic [W-1:0]  quo_q;
    logic [W-1:0]  dvs_q;
    logic [CW-1:0] cnt_q;
    logic [W:0]    shifted;
    logic [W:0]    trial;

    // W+1-bit partial remainder: shift in next dividend bit, trial subtract
    always_comb begin
        shifted = {rem_q, quo_q[W-1]};
        trial   = shifted - {1'b0, dvs_q};
    end

    // Dividend bits leave quo_q from the top as quotient bits enter below
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend_i;
            dvs_q <= divisor_i;
            cnt_q <= '0;
        end else if (step) begin
            if (!trial[W]) begin
                rem_q <= trial[W-1:0];
                quo_q <= {quo_q[W-2:0], 1'b1};
            end else begin
                rem_q <= shifted[W-1:0];
                quo_q <= {quo_q[W-2:0], 1'b0};
            end
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign quot_o = quo_q;
    assign rem_o  = rem_q;
    assign last_o = (cnt_q == CW'(W - 1));

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: M-extension sequencer with start/done handshake.
// MULDIV_SEQ_DIV_EN compiles in the iterative divider.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              kill,
    input  logic [2:0]        MDFunc,
    input  logic [DWIDTH-1:0] A,
    input  logic [DWIDTH-1:0] B,
    output logic              busy,
    output logic              done,
    output logic [DWIDTH-1:0] MDOut
);

    md_state_t         state_q;
    logic              busy_q;
    logic              done_q;
    logic [DWIDTH-1:0] mdout_q;
    logic [DWIDTH-1:0] mul_res;
    logic [DWIDTH-1:0] quick_res;
    logic              accept;

    muldiv #(.W(DWIDTH)) u_mul (
        .func (MDFunc[1:0]),
        .a    (A),
        .b    (B),
        .y    (mul_res)
    );

    assign accept = start & ~kill
                  & (state_q == S_IDLE || state_q == S_DONE);

`ifdef MULDIV_SEQ_DIV_EN
    localparam logic [DWIDTH-1:0] MIN_NEG = {1'b1, {(DWIDTH-1){1'b0}}};

    md_func_t          fn;
    logic              is_div;
    logic              is_sgn;
    logic              is_rem;
    logic              b_zero;
    logic              ovf;
    logic              go_long;
    logic              div_load;
    logic              div_step;
    logic              last;
    logic [DWIDTH-1:0] a_mag;
    logic [DWIDTH-1:0] b_mag;
    logic [DWIDTH-1:0] spec_res;
    logic [DWIDTH-1:0] quot;
    logic [DWIDTH-1:0] rem;
    logic [DWIDTH-1:0] fix_res;
    logic              qneg_q;
    logic              rneg_q;
    logic              rsel_q;

    assign fn = md_func_t'(MDFunc);

    // Decode, special-case detection and sign fix-up
    always_comb begin
        is_div = 1'b0;
        is_sgn = 1'b0;
        is_rem = 1'b0;
        unique case (fn)
            MD_DIV:  begin is_div = 1'b1; is_sgn = 1'b1; end
            MD_DIVU: begin is_div = 1'b1; end
            MD_REM:  begin is_div = 1'b1; is_sgn = 1'b1; is_rem = 1'b1; end
            MD_REMU: begin is_div = 1'b1; is_rem = 1'b1; end
            default: ;
        endcase
        b_zero = (B == '0);
        ovf    = is_sgn & (A == MIN_NEG) & (B == '1);
        a_mag  = (is_sgn & A[DWIDTH-1]) ? -A : A;
        b_mag  = (is_sgn & B[DWIDTH-1]) ? -B : B;
        if (b_zero) spec_res = is_rem ? A : '1;
        else        spec_res = is_rem ? '0 : A;
        quick_res = is_div ? spec_res : mul_res;
        go_long   = is_div & ~b_zero & ~ovf;
        div_load  = accept & go_long;
        div_step  = (state_q == S_DIV);
        fix_res   = rsel_q ? (rneg_q ? -rem : rem)
                           : (qneg_q ? -quot : quot);
    end

    div_iter #(.W(DWIDTH)) u_div (
        .clock      (clock),
        .reset      (reset),
        .load       (div_load),
        .step       (div_step),
        .dividend_i (a_mag),
        .divisor_i  (b_mag),
        .quot_o     (quot),
        .rem_o      (rem),
        .last_o     (last)
    );

    // Sequencer: kill wins, quick ops finish at once, divides iterate
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mdout_q <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            rsel_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (kill) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE, S_DONE: begin
                        if (start && go_long) begin
                            state_q <= S_DIV;
                            busy_q  <= 1'b1;
                            qneg_q  <= is_sgn & (A[DWIDTH-1] ^ B[DWIDTH-1]);
                            rneg_q  <= is_sgn & A[DWIDTH-1];
                            rsel_q  <= is_rem;
                        end else if (start) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            mdout_q <= quick_res;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                    S_DIV: begin
                        if (last) state_q <= S_FIX;
                    end
                    S_FIX: begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        mdout_q <= fix_res;
                    end
                endcase
            end
        end
    end
`else
    // Without the divider, divide functions return zero in one cycle
    always_comb begin
        quick_res = MDFunc[2] ? '0 : mul_res;
    end

    // Two-state sequencer: every accepted op completes next cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mdout_q <= '0;
        end else begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            if (accept) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                mdout_q <= quick_res;
            end else begin
                state_q <= S_IDLE;
            end
        end
    end
`endif

    assign busy  = busy_q;
    assign done  = done_q;
    assign MDOut = mdout_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: scoreboard bench for muldiv_seq.
// Divider vectors run when MULDIV_SEQ_DIV_EN is defined.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int W       = 32;
    localparam int DIV_LAT = W + 2;

    logic         clock  = 1'b0;
    logic         reset  = 1'b1;
    logic         start  = 1'b0;
    logic         kill   = 1'b0;
    logic [2:0]   MDFunc = 3'b000;
    logic [W-1:0] A      = '0;
    logic [W-1:0] B      = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] MDOut;

    logic [W-1:0] q_val[$];
    int           q_cyc[$];
    string        q_name[$];

    int cyc   = 0;
    int n_vec = 0;
    int n_bad = 0;
    int t0    = 0;

    logic [W-1:0] m_val;
    int           m_cyc;
    string        m_name;

    muldiv_seq #(.DWIDTH(W)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .kill   (kill),
        .MDFunc (MDFunc),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .MDOut  (MDOut)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Drive a request now; expected done lands lat cycles after the accepting edge
    task automatic issue(input string nm, input logic [2:0] f,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input int lat, input bit chk);
        start  = 1'b1;
        MDFunc = f;
        A      = a;
        B      = b;
        if (chk) begin
            q_val.push_back(exp);
            q_cyc.push_back(cyc + lat);
            q_name.push_back(nm);
        end
    endtask

    task automatic wait_done(input string nm, input int max);
        int k = 0;
        while (done !== 1'b1 && k < max) begin
            @(negedge clock);
            k++;
        end
        if (done !== 1'b1) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s_timeout: no done in %0d cycles, want done", nm, max);
        end
    endtask

    task automatic run(input string nm, input logic [2:0] f,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp, input int lat);
        @(negedge clock);
        issue(nm, f, a, b, exp, lat, 1'b1);
        @(negedge clock);
        start = 1'b0;
        wait_done(nm, lat + 4);
    endtask

    // Monitor: every done pops one expectation (value, cycle, busy low)
    always @(negedge clock) begin
        if (!reset && done === 1'b1) begin
            if (q_val.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_done: got done at cyc %0d want none", cyc);
            end else begin
                m_val  = q_val.pop_front();
                m_cyc  = q_cyc.pop_front();
                m_name = q_name.pop_front();
                check({m_name, "_val"}, MDOut, m_val);
                check({m_name, "_cyc"}, 32'(cyc), 32'(m_cyc));
                check({m_name, "_busy"}, 32'(busy), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clock);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out", MDOut, 32'd0);
        reset = 1'b0;

        run("mul_7", MD_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, MD_MUL_LATENCY);
        run("mulhu_ff", MD_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1);
        run("mulh_m1", MD_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1);
        run("mulhsu_m1", MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
        run("mulh_min", MD_MULH, 32'h80000000, 32'h80000000, 32'h40000000, 1);

        @(negedge clock);
        issue("b2b_a", MD_MUL, 32'd3, 32'd5, 32'd15, 1, 1'b1);
        @(negedge clock);
        issue("b2b_b", MD_MUL, 32'd6, 32'd7, 32'd42, 1, 1'b1);
        @(negedge clock);
        start = 1'b0;

        @(negedge clock);
        kill = 1'b1;
        issue("kill_start", MD_MUL, 32'd9, 32'd9, 32'd81, 1, 1'b0);
        @(negedge clock);
        start = 1'b0;
        kill  = 1'b0;
        check("kill_start_done", 32'(done), 32'd0);
        check("kill_start_out", MDOut, 32'd42);

`ifdef MULDIV_SEQ_DIV_EN
        @(negedge clock);
        t0 = cyc;
        issue("div_m7_2", MD_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, DIV_LAT, 1'b1);
        @(negedge clock);
        start = 1'b0;
        check("busy_c1", 32'(busy), 32'd1);
        while (cyc < t0 + 5) @(negedge clock);
        issue("ignored", MD_MUL, 32'd3, 32'd4, 32'd12, 1, 1'b0);
        @(negedge clock);
        start = 1'b0;
        check("busy_c6", 32'(busy), 32'd1);
        while (cyc < t0 + 33) @(negedge clock);
        check("busy_c33", 32'(busy), 32'd1);
        check("done_c33", 32'(done), 32'd0);
        wait_done("div_m7_2", 4);
        issue("b2b_div_mul", MD_MUL, 32'd2, 32'd3, 32'd6, 1, 1'b1);
        @(negedge clock);
        start = 1'b0;

        run("rem_m7_2", MD_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, DIV_LAT);
        run("divu_big", MD_DIVU, 32'hFFFFFFFF, 32'd16, 32'h0FFFFFFF, DIV_LAT);
        run("remu_big", MD_REMU, 32'hFFFFFFFF, 32'd16, 32'h0000000F, DIV_LAT);
        run("div_7_m2", MD_DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, DIV_LAT);
        run("rem_7_m2", MD_REM, 32'd7, 32'hFFFFFFFE, 32'd1, DIV_LAT);

        run("divu_by0", MD_DIVU, 32'd100, 32'd0, 32'hFFFFFFFF, 1);
        run("remu_by0", MD_REMU, 32'd100, 32'd0, 32'd100, 1);
        run("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run("rem_ovf", MD_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
        run("div_by0", MD_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 1);

        run("pre_kill", MD_MUL, 32'd6, 32'd7, 32'd42, 1);
        @(negedge clock);
        t0 = cyc;
        issue("killed", MD_DIVU, 32'd1000, 32'd3, 32'd333, DIV_LAT, 1'b0);
        @(negedge clock);
        start = 1'b0;
        while (cyc < t0 + 10) @(negedge clock);
        kill = 1'b1;
        @(negedge clock);
        kill = 1'b0;
        check("kill_busy", 32'(busy), 32'd0);
        repeat (40) @(negedge clock);
        check("kill_out", MDOut, 32'd42);
        run("post_kill", MD_MUL, 32'd5, 32'd5, 32'd25, 1);

        @(negedge clock);
        issue("reset_div", MD_DIVU, 32'd1000, 32'd3, 32'd333, DIV_LAT, 1'b0);
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_out", MDOut, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        check("post_rst_out", MDOut, 32'd0);
        run("post_rst", MD_MUL, 32'd3, 32'd4, 32'd12, 1);
`else
        run("div_nodiv", MD_DIV, 32'd9, 32'd3, 32'd0, 1);
        run("pre_remu", MD_MUL, 32'd3, 32'd4, 32'd12, 1);
        run("remu_nodiv", MD_REMU, 32'd9, 32'd4, 32'd0, 1);
        run("pre_rst", MD_MUL, 32'd3, 32'd4, 32'd12, 1);
        check("nodiv_busy", 32'(busy), 32'd0);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("rst_busy2", 32'(busy), 32'd0);
        check("rst_done2", 32'(done), 32'd0);
        check("rst_out2", MDOut, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        run("post_rst", MD_MUL, 32'd5, 32'd5, 32'd25, 1);
`endif

        repeat (5) @(negedge clock);
        check("sb_empty", 32'(q_val.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
